fetch_dual: RTL

- Dual-issue fetch stage plus F/D pipeline register. It feeds the decode stage a top/bottom instruction pair and their word PCs every cycle.
- Owns the architectural fetch PC and drives two asynchronous-read instruction-memory ports.
- Applies redirects from decode (predicted or unconditional branch or jump) and from execute (misprediction).
- On a decode bottom-slot stall, replays the bottom instruction as the next top instruction.

---
 rtl/fetch_dual.sv | 113 +++++++++++
 1 files changed

// File: rtl/fetch_dual.sv
// Dual-issue fetch stage with F/D pipeline register.
// Selects the fetch pair (redirect, bottom-slot replay or sequential) and registers it for decode.
module fetch_dual #(
  parameter int unsigned ADDR_W = 12,
  parameter logic [31:0] NOP    = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hold,
  input  logic              stall_bot,
  input  logic              dec_redirect,
  input  logic              dec_redirect_bot,
  input  logic [31:0]       dec_target,
  input  logic              ex_mispredict,
  input  logic [31:0]       ex_target,
  output logic [ADDR_W-1:0] imem_addr_top,
  output logic [ADDR_W-1:0] imem_addr_bot,
  input  logic [31:0]       imem_q_top,
  input  logic [31:0]       imem_q_bot,
  output logic [31:0]       fd_instr_top,
  output logic [31:0]       fd_instr_bot,
  output logic [31:0]       fd_pc_top,
  output logic [31:0]       fd_pc_bot,
  output logic              fd_valid_top,
  output logic              fd_valid_bot,
  output logic [ADDR_W-1:0] fetch_pc
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_top_q, instr_top_d, instr_bot_q, instr_bot_d;
  logic [ADDR_W-1:0] pct_q, pct_d, pcb_q, pcb_d;
  logic              vld_top_q, vld_top_d, vld_bot_q, vld_bot_d;

  logic              stall_eff;
  logic              redir;
  logic [ADDR_W-1:0] tgt;

  assign stall_eff = stall_bot & vld_bot_q;

  // A bottom-slot decode redirect loses to the replay; decode re-raises it from the top slot.
  assign redir = ex_mispredict
               | (dec_redirect & ~dec_redirect_bot)
               | (dec_redirect & dec_redirect_bot & ~stall_eff);
  assign tgt   = ex_mispredict ? ex_target[ADDR_W-1:0] : dec_target[ADDR_W-1:0];

  always_comb begin
    pc_d        = pc_q;
    instr_top_d = instr_top_q;
    instr_bot_d = instr_bot_q;
    pct_d       = pct_q;
    pcb_d       = pcb_q;
    vld_top_d   = vld_top_q;
    vld_bot_d   = vld_bot_q;
    imem_addr_top = pc_q;
    imem_addr_bot = pc_q + ADDR_W'(1);

    if (redir) begin
      imem_addr_top = tgt;
      imem_addr_bot = tgt + ADDR_W'(1);
    end else if (stall_eff) begin
      imem_addr_bot = pc_q;
    end

    if (!hold) begin
      if (stall_eff && !redir) begin
        instr_top_d = instr_bot_q;
        pct_d       = pcb_q;
        vld_top_d   = vld_bot_q;
        instr_bot_d = imem_q_bot;
        pcb_d       = imem_addr_bot;
        vld_bot_d   = 1'b1;
        pc_d        = pc_q + ADDR_W'(1);
      end else begin
        instr_top_d = imem_q_top;
        pct_d       = imem_addr_top;
        vld_top_d   = 1'b1;
        instr_bot_d = imem_q_bot;
        pcb_d       = imem_addr_bot;
        vld_bot_d   = 1'b1;
        pc_d        = imem_addr_top + ADDR_W'(2);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q        <= '0;
      instr_top_q <= NOP;
      instr_bot_q <= NOP;
      pct_q       <= '0;
      pcb_q       <= '0;
      vld_top_q   <= 1'b0;
      vld_bot_q   <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      instr_top_q <= instr_top_d;
      instr_bot_q <= instr_bot_d;
      pct_q       <= pct_d;
      pcb_q       <= pcb_d;
      vld_top_q   <= vld_top_d;
      vld_bot_q   <= vld_bot_d;
    end
  end

  assign fd_instr_top = instr_top_q;
  assign fd_instr_bot = instr_bot_q;
  assign fd_pc_top    = 32'(pct_q);
  assign fd_pc_bot    = 32'(pcb_q);
  assign fd_valid_top = vld_top_q;
  assign fd_valid_bot = vld_bot_q;
  assign fetch_pc     = pc_q;

endmodule
